// File: rtl/ddc_cfg_ctrl_if.sv
// Config word handshake from the control plane into ddc_cfg_ctrl.
interface ddc_cfg_ctrl_if #(
    parameter int PHASE_WIDTH = 16,
    parameter int DEC_WIDTH   = 8
);
    logic                   cfg_valid;
    logic                   cfg_ready;
    logic [PHASE_WIDTH-1:0] cfg_phase_inc;
    logic [PHASE_WIDTH-1:0] cfg_phase_offset;
    logic [DEC_WIDTH-1:0]   cfg_decimation;
    logic                   cfg_round_type;

    modport master (
        output cfg_valid, cfg_phase_inc, cfg_phase_offset, cfg_decimation, cfg_round_type,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_phase_inc, cfg_phase_offset, cfg_decimation, cfg_round_type,
        output cfg_ready
    );
endinterface

// File: rtl/ddc_cfg_ctrl.sv
// Sequences ddc reconfiguration: drain pipeline, load settings atomically, blank outputs while the FIR refills.
// Latency: new settings visible DRAIN_CYCLES+2 clocks after a RUN handshake (2 clocks from IDLE).
// Backpressure: cfg_ready low during DRAIN/LOAD/SETTLE; input samples dropped in DRAIN/LOAD are not buffered.
module ddc_cfg_ctrl #(
    parameter int PHASE_WIDTH    = 16,
    parameter int DEC_WIDTH      = 8,
    parameter int DRAIN_CYCLES   = 32,
    parameter int SETTLE_SAMPLES = 8,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    ddc_cfg_ctrl_if.slave          cfg,
    input  logic                   s_tvalid_i,
    output logic                   ddc_tvalid_o,
    output logic                   ddc_en_o,
    output logic [PHASE_WIDTH-1:0] ddc_phase_inc_o,
    output logic [PHASE_WIDTH-1:0] ddc_phase_offset_o,
    output logic [DEC_WIDTH-1:0]   ddc_decimation_o,
    output logic                   ddc_round_type_o,
    input  logic                   ddc_tvalid_i,
    output logic                   m_tvalid_o,
    output logic                   busy_o,
    output logic                   cfg_err_o
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_LOAD,
        ST_SETTLE
    } state_t;

    localparam logic [CNT_WIDTH-1:0] DRAIN_LAST  = CNT_WIDTH'(DRAIN_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] SETTLE_LAST = CNT_WIDTH'(SETTLE_SAMPLES - 1);

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d, cnt_inc;
    logic                   cfg_hs;

    logic [PHASE_WIDTH-1:0] sh_phase_inc, sh_phase_offset;
    logic [DEC_WIDTH-1:0]   sh_decimation;
    logic                   sh_round_type;

    assign cfg.cfg_ready = (state_q == ST_IDLE) || (state_q == ST_RUN);
    assign cfg_hs        = cfg.cfg_valid && cfg.cfg_ready;
    assign cnt_inc       = (cnt_q == '1) ? cnt_q : cnt_q + CNT_WIDTH'(1);

    assign ddc_en_o     = (state_q == ST_RUN) || (state_q == ST_DRAIN) || (state_q == ST_SETTLE);
    assign ddc_tvalid_o = ((state_q == ST_RUN) || (state_q == ST_SETTLE)) && s_tvalid_i;
    // Drain still forwards results computed with the old settings.
    assign m_tvalid_o   = ((state_q == ST_RUN) || (state_q == ST_DRAIN)) && ddc_tvalid_i;
    assign busy_o       = (state_q == ST_DRAIN) || (state_q == ST_LOAD) || (state_q == ST_SETTLE);

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (cfg_hs) state_d = ST_LOAD;
            end
            ST_RUN: begin
                if (cfg_hs) begin
                    state_d = ST_DRAIN;
                    cnt_d   = '0;
                end
            end
            ST_DRAIN: begin
                if (cnt_q >= DRAIN_LAST) state_d = ST_LOAD;
                else                     cnt_d   = cnt_inc;
            end
            ST_LOAD: begin
                cnt_d   = '0;
                state_d = (SETTLE_SAMPLES == 0) ? ST_RUN : ST_SETTLE;
            end
            ST_SETTLE: begin
                // The valid that completes the count is itself blanked.
                if (ddc_tvalid_i) begin
                    if (cnt_q >= SETTLE_LAST) state_d = ST_RUN;
                    else                      cnt_d   = cnt_inc;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sh_phase_inc    <= '0;
            sh_phase_offset <= '0;
            sh_decimation   <= DEC_WIDTH'(1);
            sh_round_type   <= 1'b0;
            cfg_err_o       <= 1'b0;
        end else begin
            cfg_err_o <= cfg_hs && (cfg.cfg_decimation == '0);
            if (cfg_hs) begin
                sh_phase_inc    <= cfg.cfg_phase_inc;
                sh_phase_offset <= cfg.cfg_phase_offset;
                sh_decimation   <= (cfg.cfg_decimation == '0) ? DEC_WIDTH'(1) : cfg.cfg_decimation;
                sh_round_type   <= cfg.cfg_round_type;
            end
        end
    end

    // All four fields move on the same edge so ddc never sees a mixed config.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ddc_phase_inc_o    <= '0;
            ddc_phase_offset_o <= '0;
            ddc_decimation_o   <= DEC_WIDTH'(1);
            ddc_round_type_o   <= 1'b0;
        end else if (state_q == ST_LOAD) begin
            ddc_phase_inc_o    <= sh_phase_inc;
            ddc_phase_offset_o <= sh_phase_offset;
            ddc_decimation_o   <= sh_decimation;
            ddc_round_type_o   <= sh_round_type;
        end
    end

endmodule

// File: tb/tb_ddc_cfg_ctrl.sv
// Randomized self-checking bench for ddc_cfg_ctrl: default build plus a no-blanking build.
module tb_ddc_cfg_ctrl;
    localparam int PW     = 16;
    localparam int DW     = 8;
    localparam int DRAIN  = 32;
    localparam int SETTLE = 8;
    localparam int DRAIN1 = 4;
    localparam int OW     = 2*PW + DW + 1;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    ddc_cfg_ctrl_if #(.PHASE_WIDTH(PW), .DEC_WIDTH(DW)) cif0 ();
    ddc_cfg_ctrl_if #(.PHASE_WIDTH(PW), .DEC_WIDTH(DW)) cif1 ();

    logic          s_tv0, ddc_tv_in0, ddc_tv0, en0, m_tv0, busy0, err0, rnd0;
    logic [PW-1:0] inc0, off0;
    logic [DW-1:0] dec0;
    logic          s_tv1, ddc_tv_in1, ddc_tv1, en1, m_tv1, busy1, err1, rnd1;
    logic [PW-1:0] inc1, off1;
    logic [DW-1:0] dec1;
    logic [OW-1:0] out0, out1;

    assign out0 = {inc0, off0, dec0, rnd0};
    assign out1 = {inc1, off1, dec1, rnd1};

    ddc_cfg_ctrl #(.PHASE_WIDTH(PW), .DEC_WIDTH(DW), .DRAIN_CYCLES(DRAIN),
                   .SETTLE_SAMPLES(SETTLE), .CNT_WIDTH(16)) dut0 (
        .clk_i(clk), .rstn_i(rstn), .cfg(cif0.slave), .s_tvalid_i(s_tv0),
        .ddc_tvalid_o(ddc_tv0), .ddc_en_o(en0), .ddc_phase_inc_o(inc0),
        .ddc_phase_offset_o(off0), .ddc_decimation_o(dec0), .ddc_round_type_o(rnd0),
        .ddc_tvalid_i(ddc_tv_in0), .m_tvalid_o(m_tv0), .busy_o(busy0), .cfg_err_o(err0)
    );

    ddc_cfg_ctrl #(.PHASE_WIDTH(PW), .DEC_WIDTH(DW), .DRAIN_CYCLES(DRAIN1),
                   .SETTLE_SAMPLES(0), .CNT_WIDTH(8)) dut1 (
        .clk_i(clk), .rstn_i(rstn), .cfg(cif1.slave), .s_tvalid_i(s_tv1),
        .ddc_tvalid_o(ddc_tv1), .ddc_en_o(en1), .ddc_phase_inc_o(inc1),
        .ddc_phase_offset_o(off1), .ddc_decimation_o(dec1), .ddc_round_type_o(rnd1),
        .ddc_tvalid_i(ddc_tv_in1), .m_tvalid_o(m_tv1), .busy_o(busy1), .cfg_err_o(err1)
    );

    int tests = 0;
    int fails = 0;

    // Reference rule: an accepted decimation of 0 is loaded as 1.
    function automatic logic [OW-1:0] expect_cfg(input logic [PW-1:0] inc, input logic [PW-1:0] off,
                                                 input logic [DW-1:0] dec, input logic rnd);
        logic [DW-1:0] d;
        d = (dec == '0) ? DW'(1) : dec;
        return {inc, off, d, rnd};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer0(input logic [PW-1:0] inc, input logic [PW-1:0] off,
                          input logic [DW-1:0] dec, input logic rnd);
        cif0.cfg_valid        = 1'b1;
        cif0.cfg_phase_inc    = inc;
        cif0.cfg_phase_offset = off;
        cif0.cfg_decimation   = dec;
        cif0.cfg_round_type   = rnd;
    endtask

    task automatic offer1(input logic [PW-1:0] inc, input logic [PW-1:0] off,
                          input logic [DW-1:0] dec, input logic rnd);
        cif1.cfg_valid        = 1'b1;
        cif1.cfg_phase_inc    = inc;
        cif1.cfg_phase_offset = off;
        cif1.cfg_decimation   = dec;
        cif1.cfg_round_type   = rnd;
    endtask

    // Feeds ddc valids every cycle until SETTLE ends; returns cycles spent (bounded).
    task automatic finish_settle(output int n);
        ddc_tv_in0 = 1'b1;
        n = 0;
        while (busy0 === 1'b1 && n < 100) begin
            tick();
            n++;
        end
        ddc_tv_in0 = 1'b0;
    endtask

    localparam logic [OW-1:0] RST_CFG = {16'h0, 16'h0, 8'h01, 1'b0};

    task automatic test_reset();
        rstn = 1'b0;
        s_tv0 = 1'b1; ddc_tv_in0 = 1'b1; s_tv1 = 1'b1; ddc_tv_in1 = 1'b1;
        cif0.cfg_valid = 1'b0; cif1.cfg_valid = 1'b0;
        repeat (3) tick();
        tests++; if ({en0, cif0.cfg_ready, ddc_tv0, m_tv0, busy0, err0} !== 6'b010000) begin fails++; $display("FAIL reset_ctrl0 got=%b exp=010000", {en0, cif0.cfg_ready, ddc_tv0, m_tv0, busy0, err0}); end
        tests++; if (out0 !== RST_CFG) begin fails++; $display("FAIL reset_cfg0 got=%h exp=%h", out0, RST_CFG); end
        tests++; if ({en1, cif1.cfg_ready, ddc_tv1, m_tv1, busy1, err1} !== 6'b010000) begin fails++; $display("FAIL reset_ctrl1 got=%b exp=010000", {en1, cif1.cfg_ready, ddc_tv1, m_tv1, busy1, err1}); end
        tests++; if (out1 !== RST_CFG) begin fails++; $display("FAIL reset_cfg1 got=%h exp=%h", out1, RST_CFG); end
    endtask

    task automatic test_first_cfg();
        logic [OW-1:0] exp;
        int nv;
        logic v, s;
        s_tv0 = 1'b0; ddc_tv_in0 = 1'b0; s_tv1 = 1'b0; ddc_tv_in1 = 1'b0;
        rstn = 1'b1;
        tick(); tick();
        tests++; if ({cif0.cfg_ready, en0, busy0} !== 3'b100) begin fails++; $display("FAIL idle_state got=%b exp=100", {cif0.cfg_ready, en0, busy0}); end
        offer0(16'h0800, 16'h0000, 8'd4, 1'b1);
        exp = expect_cfg(16'h0800, 16'h0000, 8'd4, 1'b1);
        tick();
        cif0.cfg_valid = 1'b0;
        tests++; if ({en0, busy0, cif0.cfg_ready} !== 3'b010) begin fails++; $display("FAIL idle_load_ctrl got=%b exp=010", {en0, busy0, cif0.cfg_ready}); end
        tests++; if (out0 !== RST_CFG) begin fails++; $display("FAIL idle_load_old got=%h exp=%h", out0, RST_CFG); end
        tick();
        tests++; if (out0 !== exp) begin fails++; $display("FAIL idle_new_cfg got=%h exp=%h", out0, exp); end
        nv = 0;
        for (int i = 0; i < 60; i++) begin
            v = (i % 3 != 0) ? 1'b1 : 1'($urandom_range(0, 1));
            s = 1'($urandom_range(0, 1));
            ddc_tv_in0 = v; s_tv0 = s;
            #1;
            tests++; if (m_tv0 !== (v && nv >= SETTLE)) begin fails++; $display("FAIL settle_blank i=%0d got=%b exp=%b", i, m_tv0, (v && nv >= SETTLE)); end
            tests++; if (busy0 !== (nv < SETTLE)) begin fails++; $display("FAIL settle_busy i=%0d got=%b exp=%b", i, busy0, (nv < SETTLE)); end
            tests++; if (ddc_tv0 !== s) begin fails++; $display("FAIL settle_fwd i=%0d got=%b exp=%b", i, ddc_tv0, s); end
            if (v) nv++;
            tick();
        end
        ddc_tv_in0 = 1'b0; s_tv0 = 1'b0;
    endtask

    task automatic test_drain();
        logic [OW-1:0] old_cfg, exp;
        logic [PW-1:0] off;
        logic [DW-1:0] dec;
        logic rnd, v;
        int n, en_low, en_low_at, ns;
        off = PW'($urandom); dec = DW'($urandom_range(1, 255)); rnd = 1'($urandom_range(0, 1));
        exp = expect_cfg(16'h1000, off, dec, rnd);
        old_cfg = out0;
        s_tv0 = 1'b1; ddc_tv_in0 = 1'b1;
        offer0(16'h1000, off, dec, rnd);
        #1;
        tests++; if ({m_tv0, ddc_tv0} !== 2'b11) begin fails++; $display("FAIL hs_cycle_pass got=%b exp=11", {m_tv0, ddc_tv0}); end
        tick();
        cif0.cfg_valid = 1'b0;
        n = 0; en_low = 0; en_low_at = -1;
        while (ddc_tv0 !== 1'b1 && n < 100) begin
            v = 1'($urandom_range(0, 1));
            ddc_tv_in0 = v;
            #1;
            tests++; if (m_tv0 !== ((n < DRAIN) ? v : 1'b0)) begin fails++; $display("FAIL drain_mvalid n=%0d got=%b exp=%b", n, m_tv0, ((n < DRAIN) ? v : 1'b0)); end
            tests++; if ({out0, cif0.cfg_ready} !== {old_cfg, 1'b0}) begin fails++; $display("FAIL drain_hold n=%0d got=%h exp=%h", n, {out0, cif0.cfg_ready}, {old_cfg, 1'b0}); end
            if (en0 === 1'b0) begin en_low++; en_low_at = n; end
            n++;
            tick();
        end
        tests++; if (n !== DRAIN + 1) begin fails++; $display("FAIL drain_gap got=%0d exp=%0d", n, DRAIN + 1); end
        tests++; if (en_low !== 1 || en_low_at !== DRAIN) begin fails++; $display("FAIL drain_en_low got=%0d@%0d exp=1@%0d", en_low, en_low_at, DRAIN); end
        tests++; if (out0 !== exp) begin fails++; $display("FAIL drain_new_cfg got=%h exp=%h", out0, exp); end
        finish_settle(ns);
        tests++; if (ns !== SETTLE) begin fails++; $display("FAIL drain_settle_len got=%0d exp=%0d", ns, SETTLE); end
        s_tv0 = 1'b0;
    endtask

    task automatic test_hold_settle();
        logic [OW-1:0] exp_a, exp_b;
        logic [PW-1:0] inc_b, off_b;
        logic [DW-1:0] dec_b;
        logic rnd_b;
        int n, ns;
        exp_a = expect_cfg(16'h2345, 16'h0101, 8'd7, 1'b0);
        offer0(16'h2345, 16'h0101, 8'd7, 1'b0);
        tick();
        inc_b = PW'($urandom); off_b = PW'($urandom); dec_b = DW'($urandom_range(1, 255)); rnd_b = 1'($urandom_range(0, 1));
        exp_b = expect_cfg(inc_b, off_b, dec_b, rnd_b);
        offer0(inc_b, off_b, dec_b, rnd_b);
        ddc_tv_in0 = 1'b1;
        n = 0;
        while (cif0.cfg_ready !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        tests++; if (n !== DRAIN + 1 + SETTLE) begin fails++; $display("FAIL hold_ready_low got=%0d exp=%0d", n, DRAIN + 1 + SETTLE); end
        tests++; if ({out0, busy0} !== {exp_a, 1'b0}) begin fails++; $display("FAIL hold_cfg_a got=%h exp=%h", {out0, busy0}, {exp_a, 1'b0}); end
        tick();
        cif0.cfg_valid = 1'b0;
        tests++; if ({busy0, cif0.cfg_ready} !== 2'b10) begin fails++; $display("FAIL hold_second_taken got=%b exp=10", {busy0, cif0.cfg_ready}); end
        repeat (DRAIN + 1) tick();
        tests++; if (out0 !== exp_b) begin fails++; $display("FAIL hold_cfg_b got=%h exp=%h", out0, exp_b); end
        finish_settle(ns);
        tests++; if (ns !== SETTLE) begin fails++; $display("FAIL hold_settle_len got=%0d exp=%0d", ns, SETTLE); end
    endtask

    task automatic test_dec_zero();
        logic [OW-1:0] exp;
        logic [PW-1:0] inc;
        int ns;
        inc = PW'($urandom) | PW'(1);
        exp = expect_cfg(inc, 16'h00f0, 8'd0, 1'b1);
        offer0(inc, 16'h00f0, 8'd0, 1'b1);
        tests++; if (err0 !== 1'b0) begin fails++; $display("FAIL err_before got=%b exp=0", err0); end
        tick();
        cif0.cfg_valid = 1'b0;
        tests++; if (err0 !== 1'b1) begin fails++; $display("FAIL err_pulse got=%b exp=1", err0); end
        tick();
        tests++; if (err0 !== 1'b0) begin fails++; $display("FAIL err_width got=%b exp=0", err0); end
        repeat (DRAIN) tick();
        tests++; if (out0 !== exp) begin fails++; $display("FAIL dec_clamp got=%h exp=%h", out0, exp); end
        finish_settle(ns);
        tests++; if (ns !== SETTLE) begin fails++; $display("FAIL dec_settle_len got=%0d exp=%0d", ns, SETTLE); end
    endtask

    task automatic test_reset_drain();
        offer0(PW'($urandom) | PW'(1), PW'($urandom), DW'($urandom_range(2, 255)), 1'b1);
        tick();
        cif0.cfg_valid = 1'b0;
        repeat ($urandom_range(2, 20)) tick();
        tests++; if ({busy0, en0} !== 2'b11) begin fails++; $display("FAIL mid_drain got=%b exp=11", {busy0, en0}); end
        s_tv0 = 1'b1; ddc_tv_in0 = 1'b1;
        rstn = 1'b0;
        #1;
        tests++; if ({en0, cif0.cfg_ready, ddc_tv0, m_tv0, busy0, err0} !== 6'b010000) begin fails++; $display("FAIL async_rst_ctrl got=%b exp=010000", {en0, cif0.cfg_ready, ddc_tv0, m_tv0, busy0, err0}); end
        tests++; if (out0 !== RST_CFG) begin fails++; $display("FAIL async_rst_cfg got=%h exp=%h", out0, RST_CFG); end
        tick();
        rstn = 1'b1;
        tick(); tick();
        tests++; if ({en0, cif0.cfg_ready, busy0, m_tv0} !== 4'b0100) begin fails++; $display("FAIL post_rst_idle got=%b exp=0100", {en0, cif0.cfg_ready, busy0, m_tv0}); end
        s_tv0 = 1'b0; ddc_tv_in0 = 1'b0;
    endtask

    task automatic test_no_settle();
        logic [OW-1:0] exp;
        logic [PW-1:0] inc, off;
        logic [DW-1:0] dec;
        int n;
        inc = PW'($urandom); off = PW'($urandom); dec = DW'($urandom_range(0, 255));
        exp = expect_cfg(inc, off, dec, 1'b1);
        ddc_tv_in1 = 1'b1;
        offer1(inc, off, dec, 1'b1);
        tick();
        cif1.cfg_valid = 1'b0;
        tests++; if ({en1, m_tv1, busy1} !== 3'b001) begin fails++; $display("FAIL ns_load got=%b exp=001", {en1, m_tv1, busy1}); end
        tick();
        tests++; if ({out1, en1, m_tv1, busy1} !== {exp, 3'b110}) begin fails++; $display("FAIL ns_run got=%h exp=%h", {out1, en1, m_tv1, busy1}, {exp, 3'b110}); end
        inc = PW'($urandom); off = PW'($urandom); dec = DW'($urandom_range(1, 255));
        exp = expect_cfg(inc, off, dec, 1'b0);
        offer1(inc, off, dec, 1'b0);
        tick();
        cif1.cfg_valid = 1'b0;
        n = 0;
        while (busy1 === 1'b1 && n < 50) begin
            tick();
            n++;
        end
        tests++; if (n !== DRAIN1 + 1) begin fails++; $display("FAIL ns_busy_len got=%0d exp=%0d", n, DRAIN1 + 1); end
        tests++; if ({out1, m_tv1} !== {exp, 1'b1}) begin fails++; $display("FAIL ns_no_blank got=%h exp=%h", {out1, m_tv1}, {exp, 1'b1}); end
        ddc_tv_in1 = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete (tests=%0d failed=%0d)", tests, fails);
        $fatal(1);
    end

    initial begin
        cif0.cfg_valid = 1'b0; cif0.cfg_phase_inc = '0; cif0.cfg_phase_offset = '0;
        cif0.cfg_decimation = '0; cif0.cfg_round_type = 1'b0;
        cif1.cfg_valid = 1'b0; cif1.cfg_phase_inc = '0; cif1.cfg_phase_offset = '0;
        cif1.cfg_decimation = '0; cif1.cfg_round_type = 1'b0;
        s_tv0 = 1'b0; ddc_tv_in0 = 1'b0; s_tv1 = 1'b0; ddc_tv_in1 = 1'b0;
        test_reset();
        test_first_cfg();
        test_drain();
        test_hold_settle();
        test_dec_zero();
        test_reset_drain();
        test_no_settle();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
